d_reg_pipe: RTL and testbench

D_REG_PIPE -- requirements
Module: d_reg_pipe

---
 rtl/d_reg_pipe_pkg.sv | 18 +
 rtl/pipe_stage.sv | 40 ++++
 rtl/d_reg_pipe.sv | 115 +++++++++++
 tb/tb_d_reg_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/d_reg_pipe_pkg.sv
// Shared definitions for the STFT datapath: default word width, default
// pipeline depth and a constant-friendly ceil(log2) helper.
package d_reg_pipe_pkg;

    localparam int DEFAULT_WL    = 8;
    localparam int DEFAULT_DEPTH = 4;

    // Smallest r such that 2**r >= value; clog2(1) == 0.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// One pipeline stage: a WL-bit data register plus a valid bit, with
// advance enable and synchronous flush. The flush always drops the valid
// bit; it zeroes the data bits only when CLR_DATA is set.
module pipe_stage #(
    parameter int WL       = 8,
    parameter int CLR_DATA = 1
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          en,
    input  logic          clr,
    input  logic [WL-1:0] d_data,
    input  logic          d_valid,
    output logic [WL-1:0] q_data,
    output logic          q_valid
);

    logic [WL-1:0] data_reg;
    logic          valid_reg;

    // Stage register: async reset, then flush, then advance, else hold.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (clr) begin
            valid_reg <= 1'b0;
            if (CLR_DATA != 0) begin
                data_reg <= '0;
            end
        end else if (en) begin
            data_reg  <= d_data;
            valid_reg <= d_valid;
        end
    end

    assign q_data  = data_reg;
    assign q_valid = valid_reg;

endmodule

// File: rtl/d_reg_pipe.sv
// Delay-register pipeline: DEPTH enabled stages of data+valid, a tap port
// that reads any stage, and an occupancy counter tracking how many stages
// currently hold valid data.
module d_reg_pipe
    import d_reg_pipe_pkg::*;
#(
    parameter  int WL       = DEFAULT_WL,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  int CLR_DATA = 1,
    localparam int TW       = (clog2(DEPTH) > 1) ? clog2(DEPTH) : 1,
    localparam int CW       = clog2(DEPTH + 1)
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iEN,
    input  logic          iCLR,
    input  logic          iVALID,
    input  logic [WL-1:0] iDATA,
    input  logic [TW-1:0] iTAP_SEL,
    output logic [WL-1:0] oDATA,
    output logic          oVALID,
    output logic [WL-1:0] oTAP_DATA,
    output logic          oTAP_VALID,
    output logic [CW-1:0] oCNT,
    output logic          oFULL,
    output logic          oEMPTY
);

    logic [WL-1:0]    stage_data [DEPTH];
    logic [DEPTH-1:0] stage_valid;
    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_next;
    logic [WL-1:0]    tap_data;
    logic             tap_valid;

    // Stage chain: stage 0 takes the input port, every other stage takes
    // its predecessor.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WL-1:0] stage_d_data;
            logic          stage_d_valid;

            if (gi == 0) begin : g_head
                assign stage_d_data  = iDATA;
                assign stage_d_valid = iVALID;
            end else begin : g_body
                assign stage_d_data  = stage_data[gi-1];
                assign stage_d_valid = stage_valid[gi-1];
            end

            pipe_stage #(
                .WL       (WL),
                .CLR_DATA (CLR_DATA)
            ) u_stage (
                .iCLK    (iCLK),
                .iRSTn   (iRSTn),
                .en      (iEN),
                .clr     (iCLR),
                .d_data  (stage_d_data),
                .d_valid (stage_d_valid),
                .q_data  (stage_data[gi]),
                .q_valid (stage_valid[gi])
            );
        end
    endgenerate

    // Occupancy update: one in, one out on a shift. The count never exceeds
    // DEPTH because a valid entering a full pipe always pushes one out.
    always_comb begin
        cnt_next = cnt_reg;
        if (iCLR) begin
            cnt_next = '0;
        end else if (iEN) begin
            cnt_next = cnt_reg + CW'(iVALID) - CW'(stage_valid[DEPTH-1]);
        end
    end

    // Occupancy register, cleared together with the stage valid bits.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    // Tap select: a single stage needs no mux; otherwise an out-of-range
    // select (non-power-of-2 depth) reads as an empty, zero stage.
    generate
        if (DEPTH == 1) begin : g_tap_single
            assign tap_data  = stage_data[0];
            assign tap_valid = stage_valid[0];
        end else begin : g_tap_mux
            always_comb begin
                tap_data  = '0;
                tap_valid = 1'b0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (iTAP_SEL == TW'(k)) begin
                        tap_data  = stage_data[k];
                        tap_valid = stage_valid[k];
                    end
                end
            end
        end
    endgenerate

    assign oDATA      = stage_data[DEPTH-1];
    assign oVALID     = stage_valid[DEPTH-1];
    assign oTAP_DATA  = tap_data;
    assign oTAP_VALID = tap_valid;
    assign oCNT       = cnt_reg;
    assign oFULL      = (cnt_reg == CW'(DEPTH));
    assign oEMPTY     = (cnt_reg == '0);

endmodule

// File: tb/tb_d_reg_pipe.sv
// Bench for d_reg_pipe: two instances sharing stimulus, A (DEPTH=4,
// CLR_DATA=1) and B (DEPTH=3, CLR_DATA=0), compared every cycle against an
// array model of the stage contents, plus directed constant checks.
module tb_d_reg_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       clr;
    logic       vin;
    logic [7:0] din;
    logic [1:0] tap_sel;

    logic [7:0] a_data, a_tdata;
    logic       a_valid, a_tvalid, a_full, a_empty;
    logic [2:0] a_cnt;

    logic [7:0] b_data, b_tdata;
    logic       b_valid, b_tvalid, b_full, b_empty;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // Model: entry = {valid, data}; index 0 is the newest stage.
    logic [8:0] ma [4];
    logic [8:0] mb [3];

    always #5 clk = ~clk;

    d_reg_pipe #(.WL(8), .DEPTH(4), .CLR_DATA(1)) dut_a (
        .iCLK(clk), .iRSTn(rst_n), .iEN(en), .iCLR(clr), .iVALID(vin),
        .iDATA(din), .iTAP_SEL(tap_sel),
        .oDATA(a_data), .oVALID(a_valid), .oTAP_DATA(a_tdata),
        .oTAP_VALID(a_tvalid), .oCNT(a_cnt), .oFULL(a_full), .oEMPTY(a_empty)
    );

    d_reg_pipe #(.WL(8), .DEPTH(3), .CLR_DATA(0)) dut_b (
        .iCLK(clk), .iRSTn(rst_n), .iEN(en), .iCLR(clr), .iVALID(vin),
        .iDATA(din), .iTAP_SEL(tap_sel),
        .oDATA(b_data), .oVALID(b_valid), .oTAP_DATA(b_tdata),
        .oTAP_VALID(b_tvalid), .oCNT(b_cnt), .oFULL(b_full), .oEMPTY(b_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        foreach (ma[i]) ma[i] = '0;
        foreach (mb[i]) mb[i] = '0;
    endtask

    // Clock edge: flush wins over advance; A drops everything, B keeps data.
    task automatic model_edge();
        if (clr) begin
            foreach (ma[i]) ma[i] = '0;
            foreach (mb[i]) mb[i][8] = 1'b0;
        end else if (en) begin
            for (int k = 3; k > 0; k--) ma[k] = ma[k-1];
            for (int k = 2; k > 0; k--) mb[k] = mb[k-1];
            ma[0] = {vin, din};
            mb[0] = {vin, din};
        end
    endtask

    task automatic check_all(input string tag);
        int ca;
        int cb;
        logic [8:0] ta;
        logic [8:0] tb;
        ca = 0;
        cb = 0;
        foreach (ma[i]) ca += int'(ma[i][8]);
        foreach (mb[i]) cb += int'(mb[i][8]);
        ta = ma[tap_sel];
        tb = (tap_sel < 2'd3) ? mb[tap_sel] : 9'h000;
        chk({tag, " a.data"},   32'(a_data),   32'(ma[3][7:0]));
        chk({tag, " a.valid"},  32'(a_valid),  32'(ma[3][8]));
        chk({tag, " a.cnt"},    32'(a_cnt),    32'(ca));
        chk({tag, " a.full"},   32'(a_full),   32'(ca == 4));
        chk({tag, " a.empty"},  32'(a_empty),  32'(ca == 0));
        chk({tag, " a.tdata"},  32'(a_tdata),  32'(ta[7:0]));
        chk({tag, " a.tvalid"}, 32'(a_tvalid), 32'(ta[8]));
        chk({tag, " b.data"},   32'(b_data),   32'(mb[2][7:0]));
        chk({tag, " b.valid"},  32'(b_valid),  32'(mb[2][8]));
        chk({tag, " b.cnt"},    32'(b_cnt),    32'(cb));
        chk({tag, " b.full"},   32'(b_full),   32'(cb == 3));
        chk({tag, " b.empty"},  32'(b_empty),  32'(cb == 0));
        chk({tag, " b.tdata"},  32'(b_tdata),  32'(tb[7:0]));
        chk({tag, " b.tvalid"}, 32'(b_tvalid), 32'(tb[8]));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic push(input string tag, input logic v, input logic [7:0] d);
        en  = 1'b1;
        clr = 1'b0;
        vin = v;
        din = d;
        tick(tag);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; vin = 1'b0; din = '0; tap_sel = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst_n = 1'b1;

        // Fill A with 11,22,33,44: the first word reaches the output on the 4th edge.
        push("load", 1'b1, 8'h11);
        push("load", 1'b1, 8'h22);
        push("load", 1'b1, 8'h33);
        push("load", 1'b1, 8'h44);
        chk("fill a.data", 32'(a_data), 32'h11);
        chk("fill a.valid", 32'(a_valid), 32'h1);
        chk("fill a.cnt", 32'(a_cnt), 32'd4);
        chk("fill a.full", 32'(a_full), 32'h1);

        // Hold for three cycles, then shift a bubble in.
        en = 1'b0;
        repeat (3) tick("hold");
        chk("hold a.data", 32'(a_data), 32'h11);
        push("bubble", 1'b0, 8'h55);
        chk("bubble a.data", 32'(a_data), 32'h22);
        chk("bubble a.cnt", 32'(a_cnt), 32'd3);

        // Refill both, then flush with enable also high.
        push("refill", 1'b1, 8'h71);
        push("refill", 1'b1, 8'h72);
        push("refill", 1'b1, 8'h73);
        push("refill", 1'b1, 8'h74);
        chk("refill a.full", 32'(a_full), 32'h1);
        en = 1'b1; clr = 1'b1; vin = 1'b1; din = 8'hEE;
        tick("clear");
        chk("clear a.cnt", 32'(a_cnt), 32'd0);
        chk("clear a.empty", 32'(a_empty), 32'h1);
        chk("clear a.data", 32'(a_data), 32'h00);
        chk("clear b.data held", 32'(b_data), 32'h72);
        chk("clear b.valid", 32'(b_valid), 32'h0);

        // Depth-3 tap sweep after loading A1,B2,C3.
        push("tapload", 1'b1, 8'hA1);
        push("tapload", 1'b1, 8'hB2);
        push("tapload", 1'b1, 8'hC3);
        en = 1'b0;
        tap_sel = 2'd0; #1; check_all("tap0"); chk("tap0 b.tdata", 32'(b_tdata), 32'hC3);
        tap_sel = 2'd1; #1; check_all("tap1"); chk("tap1 b.tdata", 32'(b_tdata), 32'hB2);
        tap_sel = 2'd2; #1; check_all("tap2"); chk("tap2 b.tdata", 32'(b_tdata), 32'hA1);
        tap_sel = 2'd3; #1; check_all("tap3");
        chk("tap3 b.tdata", 32'(b_tdata), 32'h00);
        chk("tap3 b.tvalid", 32'(b_tvalid), 32'h0);

        // Continuous valid stream into a full pipe: count pinned at depth.
        push("stream", 1'b1, 8'hD0);
        for (int i = 1; i < 9; i++) begin
            push("stream", 1'b1, 8'(8'hD0 + i));
            chk("stream a.cnt", 32'(a_cnt), 32'd4);
            chk("stream b.cnt", 32'(b_cnt), 32'd3);
        end

        // Asynchronous reset between edges, then reload as after power-up.
        en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst a.data", 32'(a_data), 32'h00);
        chk("async_rst a.empty", 32'(a_empty), 32'h1);
        @(negedge clk);
        rst_n = 1'b1;
        push("reload", 1'b1, 8'h11);
        push("reload", 1'b1, 8'h22);
        push("reload", 1'b1, 8'h33);
        push("reload", 1'b1, 8'h44);
        chk("reload a.data", 32'(a_data), 32'h11);
        chk("reload a.cnt", 32'(a_cnt), 32'd4);
        chk("reload a.full", 32'(a_full), 32'h1);

        // Randomised traffic against the model.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 3) != 0);
            clr     = ($urandom_range(0, 19) == 0);
            vin     = 1'($urandom);
            din     = 8'($urandom);
            tap_sel = 2'($urandom);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
